// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and error-bit indices for the register file
// and its pending-load scoreboard.
package regfile_pkg;

    localparam int unsigned XLEN_DEF     = 32;
    localparam int unsigned NREG_DEF     = 32;
    localparam int unsigned MAX_PEND_DEF = 4;

    // Bit positions inside the sticky err vector
    localparam int unsigned ERR_WAW  = 0;
    localparam int unsigned ERR_SPUR = 1;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// rf_scoreboard: busy vector, outstanding-load counter, issue handshake and
// sticky error flags for regfile_sb. Register 0 is never marked busy.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREG     = NREG_DEF,
    parameter int unsigned AW       = $clog2(NREG),
    parameter int unsigned MAX_PEND = MAX_PEND_DEF,
    parameter int unsigned PW       = $clog2(MAX_PEND + 1)
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            issue_valid_i,
    input  logic [AW-1:0]   issue_rd_i,
    output logic            issue_ready_o,
    input  logic            ret_valid_i,
    input  logic [AW-1:0]   ret_rd_i,
    input  logic            wa_en_i,
    input  logic [AW-1:0]   wa_addr_i,
    output logic            wa_accept_o,
    output logic [NREG-1:0] busy_o,
    output logic [PW-1:0]   pend_cnt_o,
    output logic [1:0]      err_o
);

    localparam logic [PW-1:0] MAXP = PW'(MAX_PEND);

    logic [NREG-1:0] busy_q, busy_d;
    logic [PW-1:0]   pend_q, pend_d;
    logic [1:0]      err_q, err_d;

    logic issue_acc, ret_nz, ret_hit, ret_spur, same_rd;
    logic wa_nz, wa_conf, inc, dec;

    // Hazard decode and next-state computation for busy, count and errors
    always_comb begin
        issue_ready_o = (pend_q < MAXP) && !busy_q[issue_rd_i];
        issue_acc     = issue_valid_i && issue_ready_o && (issue_rd_i != '0);
        ret_nz        = ret_valid_i && (ret_rd_i != '0);
        ret_hit       = ret_nz && busy_q[ret_rd_i];
        ret_spur      = ret_nz && !busy_q[ret_rd_i];
        same_rd       = issue_acc && ret_nz && (issue_rd_i == ret_rd_i);
        wa_nz         = wa_en_i && (wa_addr_i != '0);
        wa_conf       = wa_nz && (busy_q[wa_addr_i] ||
                                  (ret_valid_i && (ret_rd_i == wa_addr_i)));
        wa_accept_o   = wa_nz && !wa_conf;

        busy_d = busy_q;
        if (ret_hit)   busy_d[ret_rd_i]   = 1'b0;
        if (issue_acc) busy_d[issue_rd_i] = 1'b1;

        // A same-rd issue+return reuses the slot; the counter never goes below zero
        inc = issue_acc && !same_rd;
        dec = ret_hit && ((pend_q != '0) || inc);
        pend_d = pend_q;
        if (inc && !dec)      pend_d = pend_q + PW'(1);
        else if (!inc && dec) pend_d = pend_q - PW'(1);

        err_d = err_q;
        if (wa_conf)  err_d[ERR_WAW]  = 1'b1;
        if (ret_spur) err_d[ERR_SPUR] = 1'b1;
    end

    // Scoreboard state registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            busy_q <= '0;
            pend_q <= '0;
            err_q  <= '0;
        end else begin
            busy_q <= busy_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    assign busy_o     = busy_q;
    assign pend_cnt_o = pend_q;
    assign err_o      = err_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: two-read/two-write integer register file with pending-load
// scoreboard. Optional same-cycle forwarding under `REGFILE_BYPASS_EN`.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned NREG     = NREG_DEF,
    parameter int unsigned AW       = $clog2(NREG),
    parameter int unsigned MAX_PEND = MAX_PEND_DEF
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [AW-1:0]                    rs1,
    input  logic [AW-1:0]                    rs2,
    output logic [XLEN-1:0]                  src1,
    output logic [XLEN-1:0]                  src2,
    output logic                             rs1_busy,
    output logic                             rs2_busy,
    output logic                             stall,
    input  logic                             wa_en,
    input  logic [AW-1:0]                    wa_addr,
    input  logic [XLEN-1:0]                  wa_data,
    input  logic                             ld_issue_valid,
    input  logic [AW-1:0]                    ld_issue_rd,
    output logic                             ld_issue_ready,
    input  logic                             ld_ret_valid,
    input  logic [AW-1:0]                    ld_ret_rd,
    input  logic [XLEN-1:0]                  ld_ret_data,
    output logic [$clog2(MAX_PEND+1)-1:0]    pend_cnt,
    output logic [1:0]                       err
);

    localparam int unsigned PW = $clog2(MAX_PEND + 1);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy;
    logic            wa_accept;
    logic            ret_write;

    rf_scoreboard #(
        .NREG     (NREG),
        .AW       (AW),
        .MAX_PEND (MAX_PEND),
        .PW       (PW)
    ) u_sb (
        .clk_i         (clk),
        .reset_i       (reset),
        .issue_valid_i (ld_issue_valid),
        .issue_rd_i    (ld_issue_rd),
        .issue_ready_o (ld_issue_ready),
        .ret_valid_i   (ld_ret_valid),
        .ret_rd_i      (ld_ret_rd),
        .wa_en_i       (wa_en),
        .wa_addr_i     (wa_addr),
        .wa_accept_o   (wa_accept),
        .busy_o        (busy),
        .pend_cnt_o    (pend_cnt),
        .err_o         (err)
    );

    assign ret_write = ld_ret_valid && (ld_ret_rd != '0);

    // Write arbitration; port A is already blocked when it collides with a return
    always_comb begin
        regs_d = regs_q;
        if (ret_write) regs_d[ld_ret_rd] = ld_ret_data;
        if (wa_accept) regs_d[wa_addr]   = wa_data;
    end

    // Register array with synchronous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports: x0 forced to zero, optional forwarding with load return first
    always_comb begin
`ifdef REGFILE_BYPASS_EN
        if (rs1 == '0)                             src1 = '0;
        else if (ret_write && (ld_ret_rd == rs1))  src1 = ld_ret_data;
        else if (wa_accept && (wa_addr == rs1))    src1 = wa_data;
        else                                       src1 = regs_q[rs1];
        if (rs2 == '0)                             src2 = '0;
        else if (ret_write && (ld_ret_rd == rs2))  src2 = ld_ret_data;
        else if (wa_accept && (wa_addr == rs2))    src2 = wa_data;
        else                                       src2 = regs_q[rs2];
        rs1_busy = busy[rs1] && !(ld_ret_valid && (ld_ret_rd == rs1));
        rs2_busy = busy[rs2] && !(ld_ret_valid && (ld_ret_rd == rs2));
`else
        src1     = (rs1 == '0) ? '0 : regs_q[rs1];
        src2     = (rs2 == '0) ? '0 : regs_q[rs2];
        rs1_busy = busy[rs1];
        rs2_busy = busy[rs2];
`endif
        stall = rs1_busy || rs2_busy;
    end

endmodule
